// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector.
// Matches a 1..MAX_LEN bit pattern on a qualified bit stream. Supports overlapping or
// non-overlapping matches, Mealy or Moore output timing, and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LW          = 4,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = 8'b0000_1011,
  parameter int unsigned        DEFAULT_LEN = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               din_valid,
  input  logic               din,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      len_in,
  input  logic               overlap_en,
  input  logic               moore_mode,
  input  logic               clr_cnt,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LW-1:0] MaxLenW = LW'(MAX_LEN);
  localparam logic [LW-1:0] DefLenW = LW'(DEFAULT_LEN);

  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  // The oldest history bit can never take part in a match because the compare window
  // already includes the incoming bit, so only MAX_LEN-1 past bits are stored.
  logic [MAX_LEN-2:0] hist_q;
  logic [LW-1:0]      fill_q;
  logic               match_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic               fill_ok;
  logic               match;
  logic [LW-1:0]      fill_inc;
  logic [LW-1:0]      len_load;

  // Raw match: incoming bit plus stored history compared against the low len pattern bits.
  always_comb begin
    window = {hist_q, din};
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    // len_q is never zero, so len_q - 1 cannot wrap.
    fill_ok  = (fill_q >= (len_q - LW'(1)));
    match    = din_valid & ~pat_load & fill_ok & (((window ^ pat_q) & len_mask) == '0);
    fill_inc = (fill_q >= len_q) ? len_q : fill_q + LW'(1);
    len_load = ((len_in == '0) || (len_in > MaxLenW)) ? MaxLenW : len_in;
  end

  // Pattern registers, bit history and fill count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q  <= DEFAULT_PAT;
      len_q  <= DefLenW;
      hist_q <= '0;
      fill_q <= '0;
    end else if (pat_load) begin
      pat_q  <= pat_in;
      len_q  <= len_load;
      fill_q <= '0;
    end else if (din_valid) begin
      hist_q <= window[MAX_LEN-2:0];
      fill_q <= (match && !overlap_en) ? '0 : fill_inc;
    end
  end

  // Registered match for Moore timing; a pattern load cancels any pending pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q <= 1'b0;
    end else if (pat_load) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  // Saturating match counter; clear wins over a simultaneous match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Output select; gated by reset so a Mealy output also drops while reset is held.
  always_comb begin
    dout = reset_n & (moore_mode ? match_q : match);
  end

  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a stream-level reference model predicts dout
// and both counters each cycle; a negedge monitor pops and compares.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       din_valid, din, pat_load, overlap_en, moore_mode, clr_cnt;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       dout, dout2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .LW(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_in(pat_in), .len_in(len_in), .overlap_en(overlap_en), .moore_mode(moore_mode),
    .clr_cnt(clr_cnt), .dout(dout), .match_cnt(match_cnt)
  );

  // Narrow counter instance to exercise saturation.
  seq_detector_param #(.MAX_LEN(8), .LW(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_in(pat_in), .len_in(len_in), .overlap_en(overlap_en), .moore_mode(moore_mode),
    .clr_cnt(clr_cnt), .dout(dout2), .match_cnt(match_cnt2)
  );

  typedef struct packed {
    logic       dout;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: pattern, length, bits received since the last restart.
  logic [7:0] pat_m;
  int         len_m;
  bit         fresh[$];
  bit         mq_m;
  int         cnt_m, cnt2_m;
  logic       ov, mo;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Match when the last len-1 fresh bits followed by d spell the pattern, first bit pat[len-1].
  function automatic bit model_match(input logic v, input logic d, input logic ld);
    int n;
    if (!v || ld) return 1'b0;
    n = fresh.size();
    if (n < len_m - 1) return 1'b0;
    for (int k = 0; k < len_m - 1; k++) begin
      if (fresh[n - (len_m - 1) + k] != pat_m[len_m - 1 - k]) return 1'b0;
    end
    return (d == pat_m[0]);
  endfunction

  task automatic model_reset();
    pat_m = 8'b0000_1011;
    len_m = 4;
    fresh.delete();
    mq_m   = 1'b0;
    cnt_m  = 0;
    cnt2_m = 0;
  endtask

  task automatic cycle(input logic v, input logic d, input logic ld, input logic [7:0] pi,
                       input logic [3:0] li, input logic clr);
    exp_t e;
    bit   m;
    @(posedge clk); #1;
    din_valid = v; din = d; pat_load = ld; pat_in = pi; len_in = li; clr_cnt = clr;
    overlap_en = ov; moore_mode = mo;
    m = model_match(v, d, ld);
    e.dout = mo ? mq_m : m;
    e.cnt  = 8'(cnt_m);
    e.cnt2 = 2'(cnt2_m);
    sb.push_back(e);
    // State after the coming edge.
    if (clr) begin
      cnt_m = 0; cnt2_m = 0;
    end else if (m) begin
      if (cnt_m < 255) cnt_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
    if (ld) begin
      pat_m = pi;
      len_m = (li == 0 || li > 8) ? 8 : int'(li);
      fresh.delete();
      mq_m = 1'b0;
    end else begin
      mq_m = m;
      if (v) begin
        if (m && !ov) fresh.delete();
        else begin
          fresh.push_back(d);
          if (fresh.size() > 16) void'(fresh.pop_front());
        end
      end
    end
  endtask

  task automatic bit_in(input logic d);
    cycle(1'b1, d, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  task automatic gap();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  task automatic load(input logic [7:0] pi, input logic [3:0] li);
    cycle(1'b0, 1'b0, 1'b1, pi, li, 1'b0);
  endtask

  task automatic stream_1011011();
    logic [6:0] s;
    s = 7'b1011011;
    for (int i = 6; i >= 0; i--) bit_in(s[i]);
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("dout", int'(dout), int'(e.dout));
      chk("dout_w2", int'(dout2), int'(e.dout));
      chk("match_cnt", int'(match_cnt), int'(e.cnt));
      chk("match_cnt_w2", int'(match_cnt2), int'(e.cnt2));
    end
  end

  initial begin
    reset_n = 1'b0;
    din_valid = 0; din = 0; pat_load = 0; pat_in = 0; len_in = 0; clr_cnt = 0;
    overlap_en = 0; moore_mode = 0;
    ov = 1'b1; mo = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_dout", int'(dout), 0);
    chk("reset_cnt", int'(match_cnt), 0);
    reset_n = 1'b1;

    // Default pattern 1011, overlap, Mealy.
    stream_1011011();
    // Non-overlap.
    ov = 1'b0;
    load(8'b0000_1011, 4'd4);
    stream_1011011();
    // Moore timing.
    ov = 1'b1; mo = 1'b1;
    load(8'b0000_1011, 4'd4);
    stream_1011011();
    gap(); gap();
    // Gapped stream, Mealy.
    mo = 1'b0;
    load(8'b0000_1011, 4'd4);
    bit_in(1'b1); bit_in(1'b0); gap(); gap(); bit_in(1'b1); bit_in(1'b1);
    // Load 111 with a valid 1 in the same cycle; that bit must be dropped.
    cycle(1'b1, 1'b1, 1'b1, 8'b0000_0111, 4'd3, 1'b0);
    repeat (5) bit_in(1'b1);
    ov = 1'b0;
    load(8'b0000_0111, 4'd3);
    repeat (5) bit_in(1'b1);
    // Clear on a match cycle, then saturate the narrow counter.
    ov = 1'b1;
    load(8'b0000_0111, 4'd3);
    bit_in(1'b1); bit_in(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1);
    repeat (7) bit_in(1'b1);
    // Length 1 and out-of-range length codes.
    load(8'b0000_0001, 4'd1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    load(8'b1010_0101, 4'd0);
    for (int i = 7; i >= 0; i--) bit_in(pat_m[i]);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) ov = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) mo = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0), 8'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset mid-stream while a Moore pulse is being shown.
    ov = 1'b1; mo = 1'b1;
    load(8'b0000_1011, 4'd4);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    @(posedge clk); #1;
    din_valid = 1'b1; din = 1'b0; pat_load = 1'b0; clr_cnt = 1'b0;
    #1;
    chk("pre_reset_cnt", int'(match_cnt), cnt_m);
    reset_n = 1'b0;
    #1;
    chk("async_reset_dout", int'(dout), 0);
    chk("async_reset_cnt", int'(match_cnt), 0);
    chk("async_reset_cnt_w2", int'(match_cnt2), 0);
    #1;
    reset_n = 1'b1;
    model_reset();
    // Default pattern must be back.
    mo = 1'b0;
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    gap();

    repeat (3) @(posedge clk);
    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the team's fixed 4-bit Mealy sequence detector.
- Detects a runtime-programmable serial pattern of 1..MAX_LEN bits on a qualified bit stream.
- Supports overlap/non-overlap mode, Mealy or Moore output timing, and a saturating match counter.
- Sits after the serial bit source; dout feeds downstream framing/alert logic, and match_cnt is readable by status logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16).
- LW, 4, width of len_in; must satisfy 2^LW > MAX_LEN.
- CNT_W, 8, width of match_cnt.
- DEFAULT_PAT, 8'b0000_1011, pattern loaded at reset; width MAX_LEN.
- DEFAULT_LEN, 4, pattern length loaded at reset.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- din_valid  in  1  din is a valid stream bit this cycle.
- din  in  1  serial data bit.
- pat_load  in  1  latch pat_in/len_in this cycle.
- pat_in  in  MAX_LEN  new pattern; bit [len-1] is the first bit received, bit [0] the last.
- len_in  in  LW  new pattern length.
- overlap_en  in  1  1 = overlapping matches allowed.
- moore_mode  in  1  0 = Mealy (combinational) dout, 1 = Moore (registered) dout.
- clr_cnt  in  1  synchronous clear of match_cnt.
- dout  out  1  match indication.
- match_cnt  out  CNT_W  number of matches since reset/clear, saturating.

Behaviour:
- Reset (reset_n low, asynchronous) sets:
  - pat = DEFAULT_PAT, len = DEFAULT_LEN.
  - hist = 0, fill = 0.
  - match_q = 0, match_cnt = 0, dout = 0.
- hist is a MAX_LEN-bit history shift register. fill is a count of valid bits held, saturating at len.
- Shift rule: on a clock edge with din_valid=1 and pat_load=0:
  - hist <= {hist[MAX_LEN-2:0], din}.
  - fill <= min(fill+1, len).
- With din_valid=0, hist and fill hold and no match can occur.
- Raw match, combinational:
  - match = din_valid & ~pat_load & (fill >= len-1) & ({hist, din} low len bits == pat low len bits).
  - Bits above len are ignored.
  - len=1 matches every valid bit equal to pat[0].
- Non-overlap mode (overlap_en=0): on a match edge, fill <= 0, so the next match needs len fresh bits. hist still shifts.
- Overlap mode (overlap_en=1): fill is not cleared on a match. Example: pattern 11 on 111 gives matches at bits 2 and 3.
- Output timing:
  - Mealy (moore_mode=0): dout = match, in the same cycle as the final pattern bit.
  - Moore (moore_mode=1): match_q <= match every cycle; dout = match_q, one cycle after the final bit, high for exactly one cycle per match.
  - match_q is always registered, regardless of mode.
  - Changing moore_mode mid-stream takes effect immediately and may drop or repeat one pulse; this is acceptable.
- Pattern load (pat_load=1):
  - pat <= pat_in; len <= len_in, except len_in values 0 or > MAX_LEN load MAX_LEN.
  - fill <= 0 and match_q <= 0.
  - A din arriving in the same cycle is discarded: no shift, no match.
- Counter rules, in priority order:
  - clr_cnt=1 gives match_cnt <= 0, even if a match occurs that cycle.
  - Otherwise a match gives match_cnt <= match_cnt+1, saturating at all-ones.
  - Counting uses the raw match and is independent of moore_mode.
- Asynchronous reset mid-pattern forces all outputs low immediately, without waiting for a clock edge. A partial sequence in progress is lost.
- No X propagation: every register has a reset value.

Test Plan:
- Default pattern 1011, overlap=1, Mealy; valid stream 1,0,1,1,0,1,1 -> dout high at bits 4 and 7, match_cnt=2.
- Same stream, overlap=0 -> dout high at bit 4 only, match_cnt=1.
- Same stream, Moore mode -> dout high the cycle after bits 4 and 7, one cycle each.
- Stream 1,0,gap,gap,1,1 with din_valid low during the gaps -> single match at the final 1, and dout stays low during the gaps.
- Load pat=3'b111, len=3 while din_valid=1 on a 1 -> that bit ignored. Then 1,1,1,1,1 with overlap=1 -> 3 matches; with overlap=0 -> 1 match.
- Counter checks:
  - CNT_W=2 with 5 matches -> match_cnt=3.
  - clr_cnt on a match cycle -> match_cnt=0.
  - reset_n pulsed low between clock edges mid-pattern -> dout=0, match_cnt=0 immediately, and the pattern returns to 1011/len 4.
